// File: rtl/pipe_trace_buffer_if.sv
// Commit-capture and readout signal bundle for pipe_trace_buffer.
// master = pipeline/sink side, slave = trace buffer.
interface pipe_trace_buffer_if #(
  parameter int unsigned DATA_W = 64
);
  logic              cap_valid;
  logic [DATA_W-1:0] cap_pc;
  logic [31:0]       cap_instr;
  logic [4:0]        cap_rd;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_stall;
  logic              cap_err;

  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_pc;
  logic [31:0]       rd_instr;
  logic [4:0]        rd_rd;
  logic [DATA_W-1:0] rd_wdata;
  logic              rd_last;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_rd, cap_wdata, cap_stall, cap_err, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_rd, rd_wdata, rd_last
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_rd, cap_wdata, cap_stall, cap_err, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_rd, rd_wdata, rd_last
  );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Commit-trace recorder: circular capture of WB commits, freezes POST_TRIG commits after a
// trigger, then drains the captured window oldest-first over a valid/ready port.
module pipe_trace_buffer #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned POST_TRIG = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [1:0]               trig_mode,
  input  logic [DATA_W-1:0]        trig_pc,
  pipe_trace_buffer_if.slave       tr,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t DepthC = cnt_t'(DEPTH);
  localparam cnt_t PostC  = cnt_t'(POST_TRIG);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e state_q;
  ptr_t   wr_ptr_q;
  ptr_t   rd_ptr_q;
  cnt_t   fill_q;
  cnt_t   post_q;
  cnt_t   remain_q;

  logic [DATA_W-1:0] mem_pc    [DEPTH];
  logic [31:0]       mem_instr [DEPTH];
  logic [4:0]        mem_rd    [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];

  logic trig_hit;
  logic wr_en;
  logic rd_valid_w;
  logic rd_xfer;
  ptr_t wr_ptr_inc;
  cnt_t fill_inc;
  cnt_t post_inc;
  ptr_t first_ptr;

  always_comb begin
    trig_hit = 1'b0;
    unique case (trig_mode)
      2'd0: trig_hit = (tr.cap_pc == trig_pc);
      2'd1: trig_hit = tr.cap_stall;
      2'd2: trig_hit = tr.cap_err;
      2'd3: trig_hit = 1'b1;
    endcase
  end

  assign wr_en      = tr.cap_valid && ((state_q == StArmed) || (state_q == StPost));
  assign wr_ptr_inc = wr_ptr_q + ptr_t'(1);
  assign fill_inc   = (fill_q == DepthC) ? fill_q : fill_q + cnt_t'(1);
  assign post_inc   = post_q + cnt_t'(1);
  // Oldest stored entry once the final record lands; a full buffer maps back onto wr_ptr.
  assign first_ptr  = wr_ptr_inc - fill_inc[AW-1:0];

  assign rd_valid_w = (state_q == StDone) && (remain_q != '0);
  assign rd_xfer    = rd_valid_w && tr.rd_ready;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_pc[wr_ptr_q]    <= tr.cap_pc;
      mem_instr[wr_ptr_q] <= tr.cap_instr;
      mem_rd[wr_ptr_q]    <= tr.cap_rd;
      mem_wdata[wr_ptr_q] <= tr.cap_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      post_q   <= '0;
      remain_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_q  <= StArmed;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            post_q   <= '0;
          end
        end
        StArmed: begin
          if (tr.cap_valid) begin
            wr_ptr_q <= wr_ptr_inc;
            fill_q   <= fill_inc;
            if (trig_hit) begin
              post_q <= '0;
              if (POST_TRIG == 0) begin
                state_q  <= StDone;
                rd_ptr_q <= first_ptr;
                remain_q <= fill_inc;
              end else begin
                state_q <= StPost;
              end
            end
          end
        end
        StPost: begin
          if (tr.cap_valid) begin
            wr_ptr_q <= wr_ptr_inc;
            fill_q   <= fill_inc;
            post_q   <= post_inc;
            if (post_inc == PostC) begin
              state_q  <= StDone;
              rd_ptr_q <= first_ptr;
              remain_q <= fill_inc;
            end
          end
        end
        StDone: begin
          // Re-arm takes precedence over a pending transfer.
          if (arm) begin
            state_q  <= StArmed;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            post_q   <= '0;
            remain_q <= '0;
          end else if (rd_xfer) begin
            rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            remain_q <= remain_q - cnt_t'(1);
            if (remain_q == cnt_t'(1)) begin
              state_q <= StIdle;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    tr.rd_valid = rd_valid_w;
    tr.rd_last  = rd_valid_w && (remain_q == cnt_t'(1));
    tr.rd_pc    = rd_valid_w ? mem_pc[rd_ptr_q]    : '0;
    tr.rd_instr = rd_valid_w ? mem_instr[rd_ptr_q] : '0;
    tr.rd_rd    = rd_valid_w ? mem_rd[rd_ptr_q]    : '0;
    tr.rd_wdata = rd_valid_w ? mem_wdata[rd_ptr_q] : '0;
  end

  assign state = state_q;
  assign fill  = fill_q;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer with a queue-based window model checked every cycle.
module tb_pipe_trace_buffer;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned POST_TRIG = 3;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic [1:0]  trig_mode = 2'd0;
  logic [63:0] trig_pc = '0;
  logic [1:0]  state;
  logic [3:0]  fill;

  int n_checks = 0;
  int n_errors = 0;

  pipe_trace_buffer_if #(.DATA_W(DATA_W)) bus ();

  pipe_trace_buffer #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .POST_TRIG(POST_TRIG)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .arm      (arm),
    .trig_mode(trig_mode),
    .trig_pc  (trig_pc),
    .tr       (bus),
    .state    (state),
    .fill     (fill)
  );

  always #5 clock = ~clock;

  // Model: every record stored since arm, and the frozen window being drained.
  int   m_state = 0;
  int   m_post  = 0;
  rec_t hist[$];
  rec_t win[$];

  logic [63:0] got_pc[$];
  logic        got_last[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk_rec(input logic [63:0] pc);
    rec_t r;
    r.pc    = pc;
    r.instr = {16'hc0de, pc[15:0]};
    r.rd    = pc[6:2];
    r.wdata = pc ^ 64'h5a5a_0000_a5a5_0000;
    return r;
  endfunction

  task automatic freeze_window();
    int n;
    int s;
    win.delete();
    n = hist.size();
    s = (n > DEPTH) ? DEPTH : n;
    for (int i = n - s; i < n; i++) win.push_back(hist[i]);
    m_state = 3;
  endtask

  task automatic model_step();
    rec_t r;
    logic hit;
    r.pc    = bus.cap_pc;
    r.instr = bus.cap_instr;
    r.rd    = bus.cap_rd;
    r.wdata = bus.cap_wdata;
    case (trig_mode)
      2'd0:    hit = (bus.cap_pc == trig_pc);
      2'd1:    hit = bus.cap_stall;
      2'd2:    hit = bus.cap_err;
      default: hit = 1'b1;
    endcase
    case (m_state)
      0: if (arm) begin m_state = 1; hist.delete(); end
      1: if (bus.cap_valid) begin
        hist.push_back(r);
        if (hit) begin
          m_post = 0;
          if (POST_TRIG == 0) freeze_window();
          else m_state = 2;
        end
      end
      2: if (bus.cap_valid) begin
        hist.push_back(r);
        m_post++;
        if (m_post == POST_TRIG) freeze_window();
      end
      default: begin
        if (arm) begin
          m_state = 1;
          hist.delete();
          win.delete();
        end else if (win.size() > 0 && bus.rd_ready) begin
          void'(win.pop_front());
          if (win.size() == 0) m_state = 0;
        end
      end
    endcase
  endtask

  task automatic model_compare();
    logic        v;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic [4:0]  e_rd;
    logic [63:0] e_wdata;
    int          f;
    v       = (m_state == 3) && (win.size() > 0);
    e_pc    = v ? win[0].pc : '0;
    e_instr = v ? win[0].instr : '0;
    e_rd    = v ? win[0].rd : '0;
    e_wdata = v ? win[0].wdata : '0;
    f       = (hist.size() > DEPTH) ? DEPTH : hist.size();
    chk("cyc state", 64'(state), 64'(m_state));
    chk("cyc fill", 64'(fill), 64'(f));
    chk("cyc rd_valid", 64'(bus.rd_valid), 64'(v));
    chk("cyc rd_last", 64'(bus.rd_last), 64'(v && win.size() == 1));
    chk("cyc rd_pc", bus.rd_pc, e_pc);
    chk("cyc rd_instr", 64'(bus.rd_instr), 64'(e_instr));
    chk("cyc rd_rd", 64'(bus.rd_rd), 64'(e_rd));
    chk("cyc rd_wdata", bus.rd_wdata, e_wdata);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      if (!reset) model_step();
      @(negedge clock);
      if (reset) begin
        m_state = 0;
        m_post  = 0;
        hist.delete();
        win.delete();
      end else begin
        model_compare();
        if (bus.rd_valid && bus.rd_ready) begin
          got_pc.push_back(bus.rd_pc);
          got_last.push_back(bus.rd_last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic err, input logic stall);
    rec_t r;
    r = mk_rec(pc);
    bus.cap_valid = 1'b1;
    bus.cap_pc    = r.pc;
    bus.cap_instr = r.instr;
    bus.cap_rd    = r.rd;
    bus.cap_wdata = r.wdata;
    bus.cap_err   = err;
    bus.cap_stall = stall;
    tick();
    bus.cap_valid = 1'b0;
    bus.cap_err   = 1'b0;
    bus.cap_stall = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state != 2'd0 && n < 50) begin
      tick();
      n++;
    end
    if (state != 2'd0) chk({name, " idle timeout"}, 64'(state), 64'd0);
  endtask

  task automatic check_got(input string name, input logic [63:0] base, input int n);
    chk({name, " count"}, 64'(got_pc.size()), 64'(n));
    for (int i = 0; i < n && i < got_pc.size(); i++) begin
      chk({name, " pc"}, got_pc[i], base + 64'(4 * i));
      chk({name, " last"}, 64'(got_last[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    bus.cap_valid = 1'b0;
    bus.cap_pc    = '0;
    bus.cap_instr = '0;
    bus.cap_rd    = '0;
    bus.cap_wdata = '0;
    bus.cap_stall = 1'b0;
    bus.cap_err   = 1'b0;
    bus.rd_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // 1: asynchronous reset mid-clock while ARMED
    trig_mode = 2'd0;
    trig_pc   = 64'hffff_ffff_ffff_fff0;
    pulse_arm();
    commit(64'h0, 1'b0, 1'b0);
    commit(64'h4, 1'b0, 1'b0);
    chk("t1 armed state", 64'(state), 64'd1);
    chk("t1 armed fill", 64'(fill), 64'd2);
    #1 reset = 1'b1;
    #1;
    chk("t1 reset state", 64'(state), 64'd0);
    chk("t1 reset fill", 64'(fill), 64'd0);
    chk("t1 reset rd_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    reset = 1'b0;

    // 2: PC trigger at 0x28, wrapped 8-entry window
    trig_mode    = 2'd0;
    trig_pc      = 64'h28;
    bus.rd_ready = 1'b1;
    got_pc.delete();
    got_last.delete();
    pulse_arm();
    for (int i = 0; i < 20; i++) begin
      commit(64'(4 * i), 1'b0, 1'b0);
      if (i == 13) chk("t2 done after 0x34", 64'(state), 64'd3);
    end
    wait_idle("t2");
    check_got("t2", 64'h18, 8);
    chk("t2 final state", 64'(state), 64'd0);

    // 3: short window, immediate trigger
    trig_mode = 2'd3;
    got_pc.delete();
    got_last.delete();
    bus.rd_ready = 1'b0;
    pulse_arm();
    for (int i = 0; i < 4; i++) commit(64'h100 + 64'(4 * i), 1'b0, 1'b0);
    chk("t3 fill", 64'(fill), 64'd4);
    bus.rd_ready = 1'b1;
    wait_idle("t3");
    check_got("t3", 64'h100, 4);

    // 4: backpressure holds the head record
    bus.rd_ready = 1'b0;
    got_pc.delete();
    got_last.delete();
    pulse_arm();
    for (int i = 0; i < 4; i++) commit(64'h200 + 64'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t4 hold valid", 64'(bus.rd_valid), 64'd1);
      chk("t4 hold pc", bus.rd_pc, 64'h200);
      tick();
    end
    bus.rd_ready = 1'b1;
    wait_idle("t4");
    check_got("t4", 64'h200, 4);

    // 5: error trigger qualified by cap_valid; arm ignored in POST
    trig_mode = 2'd2;
    got_pc.delete();
    got_last.delete();
    pulse_arm();
    bus.cap_err = 1'b1;
    tick();
    bus.cap_err = 1'b0;
    chk("t5 unqualified err", 64'(state), 64'd1);
    commit(64'h300, 1'b1, 1'b0);
    chk("t5 err trigger", 64'(state), 64'd2);
    pulse_arm();
    chk("t5 arm in post", 64'(state), 64'd2);
    for (int i = 1; i < 4; i++) commit(64'h300 + 64'(4 * i), 1'b0, 1'b0);
    chk("t5 done", 64'(state), 64'd3);
    wait_idle("t5");
    check_got("t5", 64'h300, 4);

    // 6: reset during POST, then re-arm mid-readout
    trig_mode    = 2'd0;
    trig_pc      = 64'h410;
    bus.rd_ready = 1'b0;
    pulse_arm();
    for (int i = 0; i < 5; i++) commit(64'h400 + 64'(4 * i), 1'b0, 1'b0);
    chk("t6 post state", 64'(state), 64'd2);
    chk("t6 post fill", 64'(fill), 64'd5);
    #1 reset = 1'b1;
    #1;
    chk("t6 reset state", 64'(state), 64'd0);
    chk("t6 reset fill", 64'(fill), 64'd0);
    tick();
    reset = 1'b0;
    trig_mode = 2'd3;
    pulse_arm();
    for (int i = 0; i < 4; i++) commit(64'h500 + 64'(4 * i), 1'b0, 1'b0);
    bus.rd_ready = 1'b1;
    tick();
    tick();
    chk("t6 mid readout", 64'(state), 64'd3);
    pulse_arm();
    bus.rd_ready = 1'b0;
    chk("t6 rearm state", 64'(state), 64'd1);
    chk("t6 rearm rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("t6 rearm fill", 64'(fill), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
